// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and parity mode constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle tick every DIVISOR clocks, restartable from zero.
module uart_baud_gen #(
    parameter int unsigned DIVISOR = 16
) (
    input  logic clock,
    input  logic preset_L,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CW-1:0] count;

    // Terminal count marks the last cycle of the current bit.
    assign tick = (count == CW'(DIVISOR - 1));

    // Count 0..DIVISOR-1, wrapping on tick; restart pins the count at zero.
    always_ff @(posedge clock or negedge preset_L) begin
        if (!preset_L) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake, LSB-first serial frame with
// optional parity and one or two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR   = 16,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 preset_L,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx
);

    localparam int unsigned BCW = $clog2(DATA_BITS + 1);

    // Reject configurations the frame format cannot represent.
    if (DIVISOR < 2) begin : g_bad_divisor
        $error("uart_tx: DIVISOR must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be 5..9");
    end
    if (PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    // The local PARITY parameter hides the imported state name, so that
    // state is always referenced through the package scope below.
    uart_state_e          state, state_next;
    logic [DATA_BITS-1:0] shift_q, shift_next;
    logic [BCW-1:0]       bit_cnt, bit_cnt_next;
    logic                 par_bit, par_next;
    logic                 tx_next;
    logic                 tick;

    // Bit timer held at zero while idle so every frame starts a fresh bit.
    uart_baud_gen #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clock    (clock),
        .preset_L (preset_L),
        .restart  (ready),
        .tick     (tick)
    );

    // Ready is a pure decode of the state register.
    assign ready = (state == IDLE);

    // State, shift register, counters and line driver.
    always_ff @(posedge clock or negedge preset_L) begin
        if (!preset_L) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            shift_q <= shift_next;
            bit_cnt <= bit_cnt_next;
            par_bit <= par_next;
            tx      <= tx_next;
        end
    end

    // Frame sequencing; tx_next is the line level for the coming cycle.
    always_comb begin
        state_next   = state;
        shift_next   = shift_q;
        bit_cnt_next = bit_cnt;
        par_next     = par_bit;
        tx_next      = tx;

        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (valid) begin
                    shift_next   = data;
                    par_next     = (PARITY == PAR_ODD) ? ~^data : ^data;
                    bit_cnt_next = '0;
                    tx_next      = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_next      = shift_q[0];
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift_q >> 1;
                    if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                        bit_cnt_next = '0;
                        if (PARITY != PAR_NONE) begin
                            tx_next    = par_bit;
                            state_next = uart_pkg::PARITY;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + BCW'(1);
                        tx_next      = shift_q[1];
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    tx_next      = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = STOP;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (tick) begin
                    if (bit_cnt == BCW'(STOP_BITS - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + BCW'(1);
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances (no/even/odd parity, two
// stop bits) checked cycle by cycle against a frame-level line model.
module tb_uart_tx;

    localparam int unsigned D = 4;

    logic       clock = 1'b0;
    logic       preset_L = 1'b1;
    logic [7:0] data  [4];
    logic       valid [4];
    logic       tx    [4];
    logic       ready [4];

    int n_checks = 0;
    int n_pass   = 0;
    int got_q[$];
    int exp_q[$];

    always #5 clock = ~clock;

    uart_tx #(.DIVISOR(D), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clock(clock), .preset_L(preset_L), .data(data[0]), .valid(valid[0]),
        .ready(ready[0]), .tx(tx[0]));
    uart_tx #(.DIVISOR(D), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clock(clock), .preset_L(preset_L), .data(data[1]), .valid(valid[1]),
        .ready(ready[1]), .tx(tx[1]));
    uart_tx #(.DIVISOR(D), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
        .clock(clock), .preset_L(preset_L), .data(data[2]), .valid(valid[2]),
        .ready(ready[2]), .tx(tx[2]));
    uart_tx #(.DIVISOR(D), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
        .clock(clock), .preset_L(preset_L), .data(data[3]), .valid(valid[3]),
        .ready(ready[3]), .tx(tx[3]));

    typedef struct {
        int         inst;
        logic [7:0] word;
        int         exp_low;
        int         exp_par;
    } vec_t;

    function automatic int par_mode(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : 0;
    endfunction

    function automatic int stop_count(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Line model: list the frame's bit values, then stretch each to D cycles.
    task automatic build_frame(input logic [7:0] w, input int k);
        int bits[$];
        int ones;
        bits.push_back(0);
        for (int i = 0; i < 8; i++) bits.push_back(int'(w[i]));
        ones = $countones(w);
        if (par_mode(k) == 1) bits.push_back(ones % 2);
        if (par_mode(k) == 2) bits.push_back(1 - (ones % 2));
        for (int i = 0; i < stop_count(k); i++) bits.push_back(1);
        foreach (bits[i]) begin
            for (int j = 0; j < int'(D); j++) exp_q.push_back(bits[i]);
        end
    endtask

    task automatic compare_frame(input string name);
        int bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_q.size() || got_q[i] != exp_q[i]) begin
                bad = i;
                break;
            end
        end
        check(name, bad, -1);
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (ready[k] !== 1'b1 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 100) check($sformatf("wait_ready_%0d", k), 0, 1);
    endtask

    // Send one word and record the line until ready returns; optional
    // mid-frame disturbance of data/valid that must not affect the frame.
    task automatic send_check(input int k, input logic [7:0] w, input bit disturb,
                              output int low);
        int n = 0;
        wait_ready(k);
        @(negedge clock);
        data[k]  = w;
        valid[k] = 1'b1;
        @(posedge clock);
        #1;
        valid[k] = 1'b0;
        data[k]  = 8'($urandom);
        exp_q.delete();
        build_frame(w, k);
        got_q.delete();
        while (ready[k] == 1'b0 && n < 200) begin
            got_q.push_back(int'(tx[k]));
            if (disturb && n == 10) begin
                data[k]  = 8'hFF;
                valid[k] = 1'b1;
            end
            if (disturb && n == 14) valid[k] = 1'b0;
            @(posedge clock);
            #1;
            n++;
        end
        low = n;
        check($sformatf("occupancy_i%0d_%02h", k, w), n, exp_q.size());
        compare_frame($sformatf("frame_i%0d_%02h", k, w));
        check($sformatf("idle_tx_i%0d", k), int'(tx[k]), 1);
    endtask

    initial begin
        vec_t tbl[4];
        int   low;
        int   bad;
        int   idx;

        tbl[0] = '{inst: 0, word: 8'hA5, exp_low: 40, exp_par: -1};
        tbl[1] = '{inst: 1, word: 8'h07, exp_low: 44, exp_par: 1};
        tbl[2] = '{inst: 2, word: 8'h07, exp_low: 44, exp_par: 0};
        tbl[3] = '{inst: 3, word: 8'h3C, exp_low: 44, exp_par: -1};

        for (int k = 0; k < 4; k++) begin
            valid[k] = 1'b0;
            data[k]  = 8'h00;
        end

        // Asynchronous reset before the first clock edge.
        #3 preset_L = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_tx_i%0d", k), int'(tx[k]), 1);
            check($sformatf("reset_ready_i%0d", k), int'(ready[k]), 1);
        end
        repeat (3) @(posedge clock);
        @(negedge clock) preset_L = 1'b1;

        // Idle line with valid low for 50 cycles.
        bad = 0;
        repeat (50) begin
            @(posedge clock);
            #1;
            for (int k = 0; k < 4; k++) if (tx[k] != 1'b1 || ready[k] != 1'b1) bad++;
        end
        check("idle_50", bad, 0);

        // Reset pulse mid-idle.
        #2 preset_L = 1'b0;
        #1;
        check("idle_reset_tx", int'(tx[0]), 1);
        check("idle_reset_ready", int'(ready[0]), 1);
        @(negedge clock) preset_L = 1'b1;

        // Directed table: occupancy and parity bit.
        for (int i = 0; i < 4; i++) begin
            send_check(tbl[i].inst, tbl[i].word, 1'b0, low);
            check($sformatf("tbl_low_%0d", i), low, tbl[i].exp_low);
            if (tbl[i].exp_par >= 0)
                check($sformatf("tbl_parity_%0d", i), got_q[38], tbl[i].exp_par);
        end

        // Back-to-back frames, two stop bits, valid held high.
        wait_ready(3);
        @(negedge clock);
        data[3]  = 8'h55;
        valid[3] = 1'b1;
        @(posedge clock);
        #1;
        data[3] = 8'hAA;
        exp_q.delete();
        build_frame(8'h55, 3);
        exp_q.push_back(1);
        build_frame(8'hAA, 3);
        exp_q.push_back(1);
        got_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            got_q.push_back(int'(tx[3]));
            if (i == 44) check("b2b_ready_gap", int'(ready[3]), 1);
            if (i == 45) valid[3] = 1'b0;
            @(posedge clock);
            #1;
        end
        compare_frame("b2b_frames");
        idx = -1;
        for (int i = 44; i < got_q.size(); i++) begin
            if (got_q[i] == 0) begin
                idx = i;
                break;
            end
        end
        check("b2b_start_gap", idx - 36, 9);
        check("b2b_end_ready", int'(ready[3]), 1);

        // Mid-frame data/valid disturbance: frame intact, no extra frame.
        send_check(0, 8'h96, 1'b1, low);
        bad = 0;
        repeat (2 * D) begin
            @(posedge clock);
            #1;
            if (tx[0] != 1'b1 || ready[0] != 1'b1) bad++;
        end
        check("no_extra_frame", bad, 0);

        // Reset during data bit 3, then a clean frame.
        wait_ready(0);
        @(negedge clock);
        data[0]  = 8'hC3;
        valid[0] = 1'b1;
        @(posedge clock);
        #1;
        valid[0] = 1'b0;
        repeat (17) begin
            @(posedge clock);
            #1;
        end
        check("pre_reset_bit3", int'(tx[0]), 0);
        #2 preset_L = 1'b0;
        #1;
        check("midframe_reset_tx", int'(tx[0]), 1);
        check("midframe_reset_ready", int'(ready[0]), 1);
        repeat (2) @(posedge clock);
        @(negedge clock) preset_L = 1'b1;
        send_check(0, 8'h3C, 1'b0, low);

        // Randomized words on every configuration.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) begin
                send_check(k, 8'($urandom), (r == 2), low);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_tx
